// File: rtl/fpga_rst_seq_if.sv
// fpga_rst_seq_if: control/status bundle between the reset sequencer and its user.
// The sw_rst_req member exists only when FPGA_RST_SEQ_SWRST_EN is defined.
interface fpga_rst_seq_if #(
  parameter int unsigned NUM_RST = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               pll_lock;
  logic               lock_lost_clr;
`ifdef FPGA_RST_SEQ_SWRST_EN
  logic               sw_rst_req;
`endif
  logic [NUM_RST-1:0] srst;
  logic               rst_done;
  logic               lock_lost;
  logic [CNT_W-1:0]   relock_cnt;

  // Side that drives lock/requests and observes the reset outputs.
  modport master (
    output pll_lock,
    output lock_lost_clr,
`ifdef FPGA_RST_SEQ_SWRST_EN
    output sw_rst_req,
`endif
    input  srst,
    input  rst_done,
    input  lock_lost,
    input  relock_cnt
  );

  // The sequencer itself.
  modport slave (
    input  pll_lock,
    input  lock_lost_clr,
`ifdef FPGA_RST_SEQ_SWRST_EN
    input  sw_rst_req,
`endif
    output srst,
    output rst_done,
    output lock_lost,
    output relock_cnt
  );
endinterface

// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: synchronises and debounces the PLL lock, then releases NUM_RST
// synchronous resets one at a time, STAGE_GAP cycles apart. Lock loss re-asserts
// every reset at once and restarts the sequence.
// Define FPGA_RST_SEQ_SWRST_EN to add the software reset request (SWHOLD state).
module fpga_rst_seq #(
  parameter int unsigned NUM_RST       = 4,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned LOCK_DEBOUNCE = 64,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned CNT_W         = 8
) (
  input logic           clk_out0,
  input logic           arst_n,
  fpga_rst_seq_if.slave bus
);

  localparam int unsigned StW  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam int unsigned DebW = (LOCK_DEBOUNCE > 1) ? $clog2(LOCK_DEBOUNCE) : 1;
  localparam int unsigned GapW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [DebW-1:0] DebLast   = DebW'(LOCK_DEBOUNCE - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(STAGE_GAP - 1);
  localparam logic [StW-1:0]  StageLast = StW'(NUM_RST - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StRelease  = 2'd1,
    StRun      = 2'd2
`ifdef FPGA_RST_SEQ_SWRST_EN
    ,
    StSwHold   = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DebW-1:0]      deb_q, deb_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [StW-1:0]       stage_q, stage_d;
  logic [NUM_RST-1:0]   srst_q, srst_d;
  logic                 rst_done_q, rst_done_d;
  logic                 lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]     relock_q, relock_d;
  logic                 lock_s;
  logic                 lock_loss;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  // Any state other than WAIT_LOCK has committed to a lock, so losing it counts.
  assign lock_loss = !lock_s && (state_q != StWaitLock);

  // Lock synchroniser: pll_lock is asynchronous to clk_out0.
  always_ff @(posedge clk_out0 or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk_out0 or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StWaitLock;
      deb_q       <= '0;
      gap_q       <= '0;
      stage_q     <= '0;
      srst_q      <= '1;
      rst_done_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      gap_q       <= gap_d;
      stage_q     <= stage_d;
      srst_q      <= srst_d;
      rst_done_q  <= rst_done_d;
      lock_lost_q <= lock_lost_d;
      relock_q    <= relock_d;
    end
  end

  // Next-state: debounce, staged release, lock-loss and software-reset handling.
  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    gap_d       = gap_q;
    stage_d     = stage_q;
    srst_d      = srst_q;
    rst_done_d  = rst_done_q;
    lock_lost_d = lock_lost_q;
    relock_d    = relock_q;

    if (bus.lock_lost_clr) begin
      lock_lost_d = 1'b0;
    end

    unique case (state_q)
      StWaitLock: begin
        if (lock_s) begin
          if (deb_q == DebLast) begin
            state_d = StRelease;
            deb_d   = '0;
            gap_d   = '0;
            stage_d = '0;
          end else begin
            deb_d = deb_q + DebW'(1);
          end
        end else begin
          deb_d = '0;
        end
      end
      StRelease: begin
        if (gap_q == GapLast) begin
          gap_d          = '0;
          srst_d[stage_q] = 1'b0;
          if (stage_q == StageLast) begin
            state_d    = StRun;
            rst_done_d = 1'b1;
            stage_d    = '0;
          end else begin
            stage_d = stage_q + StW'(1);
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StRun: begin
        srst_d     = '0;
        rst_done_d = 1'b1;
      end
`ifdef FPGA_RST_SEQ_SWRST_EN
      StSwHold: begin
        // Lock is already known good here, so skip the debounce.
        if (gap_q == GapLast) begin
          state_d = StRelease;
          gap_d   = '0;
          stage_d = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
`endif
      default: begin
        state_d = StWaitLock;
      end
    endcase

`ifdef FPGA_RST_SEQ_SWRST_EN
    if (bus.sw_rst_req && (state_q == StRelease || state_q == StRun)) begin
      state_d    = StSwHold;
      srst_d     = '1;
      rst_done_d = 1'b0;
      deb_d      = '0;
      gap_d      = '0;
      stage_d    = '0;
    end
`endif

    // Lock loss overrides everything else; set beats a simultaneous clear.
    if (lock_loss) begin
      state_d     = StWaitLock;
      srst_d      = '1;
      rst_done_d  = 1'b0;
      deb_d       = '0;
      gap_d       = '0;
      stage_d     = '0;
      lock_lost_d = 1'b1;
      if (relock_q != '1) begin
        relock_d = relock_q + CNT_W'(1);
      end
    end
  end

  assign bus.srst       = srst_q;
  assign bus.rst_done   = rst_done_q;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.relock_cnt = relock_q;

endmodule

// File: doc/fpga_rst_seq.md
Name: fpga_rst_seq

Overview:
Parametrised reset sequencer clocked by the PLL output clock. It synchronises and debounces the PLL lock, then releases NUM_RST synchronous resets one at a time, spaced by a programmable gap. It detects lock loss at runtime, re-asserts all resets, and re-runs the sequence. It sits directly behind the top-level PLL and feeds srst to each subsystem (CSI RX, ISP, video out).

Parameters:
NUM_RST, 4, number of staged reset outputs (1..8)
SYNC_STAGES, 3, flops in the pll_lock synchroniser (>=2)
LOCK_DEBOUNCE, 64, consecutive cycles lock_s must be 1 before release starts (>=1)
STAGE_GAP, 16, cycles between successive srst releases (>=1)
CNT_W, 8, width of relock_cnt

Ports:
clk_out0  in  1  PLL output clock; all logic runs on it
arst_n  in  1  reset arst_n, asynchronous, active-low; clock clk_out0
pll_lock  in  1  raw PLL LOCKED, asynchronous to clk_out0
lock_lost_clr  in  1  sync pulse, clears lock_lost
srst  out  NUM_RST  active-high synchronous resets; bit i releases before bit i+1
rst_done  out  1  1 once all srst are released
lock_lost  out  1  sticky flag: lock dropped after the sequence had left WAIT_LOCK
relock_cnt  out  CNT_W  saturating count of lock-loss events

Behaviour:
- arst_n=0 (async):
  - srst all ones, rst_done=0, lock_lost=0, relock_cnt=0.
  - Synchroniser flops cleared to 0; debounce, gap and stage counters cleared to 0.
  - State = WAIT_LOCK.
- lock_s is the last flop of the SYNC_STAGES-deep synchroniser.
- WAIT_LOCK:
  - deb_cnt increments while lock_s=1 and clears to 0 when lock_s=0.
  - When deb_cnt reaches LOCK_DEBOUNCE-1 with lock_s=1, go to RELEASE; stage=0, gap=0.
- RELEASE:
  - gap counts 0..STAGE_GAP-1. On the edge where gap=STAGE_GAP-1: srst[stage] <= 0, gap <= 0, stage <= stage+1.
  - After srst[NUM_RST-1] clears, go to RUN. rst_done rises on the same edge.
- RUN: hold; srst=0, rst_done=1.
- Release timing:
  - srst[0] falls exactly LOCK_DEBOUNCE+STAGE_GAP edges after the first edge that samples lock_s=1.
  - srst[i] falls STAGE_GAP edges after srst[i-1].
  - srst bits only ever clear in ascending order.
- Lock loss (lock_s=0 while in RELEASE or RUN):
  - Next edge: all srst=1, rst_done=0, state=WAIT_LOCK, all counters cleared.
  - lock_lost <= 1; relock_cnt increments, saturating at 2^CNT_W-1.
- Resets are asserted simultaneously on all bits, never staged. Consumers in other clock domains re-synchronise srst locally.
- lock_lost_clr clears lock_lost. If it coincides with a new loss event, set wins.
- arst_n assertion mid-sequence overrides everything immediately. Deassertion restarts from WAIT_LOCK.
- No combinational path from any input to any output; every output is a flop.

Optional Feature:
Macro FPGA_RST_SEQ_SWRST_EN.
- Defined:
  - Adds input sw_rst_req (1 bit, sync pulse).
  - Sampled 1 in RUN or RELEASE: next edge all srst=1, rst_done=0, state=SWHOLD.
  - SWHOLD counts STAGE_GAP cycles, then enters RELEASE with no debounce.
  - srst[0] falls 2*STAGE_GAP edges after the sampling edge.
  - lock_lost and relock_cnt are not affected.
  - sw_rst_req is ignored in WAIT_LOCK and SWHOLD. Lock loss in SWHOLD behaves as a normal lock loss.
- Undefined: the port and the SWHOLD state are absent.

Test Plan:
- Defaults; arst_n low, pll_lock=1, arst_n released -> srst=4'hF until lock_s=1. srst[0..3] fall at +80/+96/+112/+128 edges. rst_done=1 at +128.
- Glitch: pll_lock high 40 cycles, low 5, high -> no srst release before 64 cycles of continuous lock_s. srst[0] falls 80 edges after the final lock_s rise.
- In RUN, drop pll_lock -> srst=4'hF one edge after lock_s falls; lock_lost=1, relock_cnt=1. Restore lock -> full 80..128 sequence repeats.
- lock_lost_clr on the same edge as a second loss -> lock_lost stays 1, relock_cnt=2. After 300 losses with CNT_W=8 -> relock_cnt=255.
- arst_n low after srst[1] released (srst=4'b1100) -> srst=4'hF asynchronously, rst_done=0, relock_cnt=0.
- FPGA_RST_SEQ_SWRST_EN: 1-cycle sw_rst_req in RUN -> srst=4'hF next edge. srst[0] falls at +32, srst[3] at +80. lock_lost and relock_cnt unchanged.
